// File: rtl/token_credit_tx_if.sv
// Handshake, link and status bundle for the token_credit_tx sender.
// master = upstream/link environment, slave = the credit manager itself.
interface token_credit_tx_if #(
  parameter int CW = 2
) ();
  logic          REQ;
  logic          RDY;
  logic          LINK_ENQ;
  logic          CRD_RET;
  logic          CLR;
  logic          CLR_DONE;
  logic [CW-1:0] CREDIT_CNT;
  logic          ERR;

  modport master (
    output REQ, CRD_RET, CLR,
    input  RDY, LINK_ENQ, CLR_DONE, CREDIT_CNT, ERR
  );

  modport slave (
    input  REQ, CRD_RET, CLR,
    output RDY, LINK_ENQ, CLR_DONE, CREDIT_CNT, ERR
  );
endinterface

// File: rtl/token_credit_tx.sv
// Sender-side credit manager for a remote dataless token FIFO of depth CREDITS.
// Optional protocol checking (sticky ERR, sim warnings) via TOKEN_CREDIT_TX_CHECK_EN.
module token_credit_tx #(
  parameter int CREDITS = 2,
  parameter int CW      = 2
) (
  input logic              CLK,
  input logic              RST,
  token_credit_tx_if.slave bus
);

  typedef enum logic [1:0] {
    INIT,
    ACTIVE,
    DRAIN
  } state_t;

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  state_t        r_state;
  logic [CW-1:0] r_credits;
  logic          r_linkEnq;
  logic          r_clrDone;

  logic          w_rdy;
  logic          w_fire;
  logic          w_atMax;
  logic [CW-1:0] w_nextCredits;

  assign w_atMax = (r_credits == FULL);
  assign w_rdy   = (r_state == ACTIVE) && (r_credits != '0) && !bus.CLR;
  assign w_fire  = bus.REQ && w_rdy;

  // A return with every credit already home saturates instead of wrapping.
  always_comb begin
    w_nextCredits = r_credits;
    if (w_fire && !bus.CRD_RET) begin
      w_nextCredits = r_credits - CW'(1);
    end else if (!w_fire && bus.CRD_RET && !w_atMax) begin
      w_nextCredits = r_credits + CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= INIT;
      r_credits <= '0;
      r_linkEnq <= 1'b0;
      r_clrDone <= 1'b0;
    end else begin
      r_linkEnq <= 1'b0;
      r_clrDone <= 1'b0;
      case (r_state)
        INIT: begin
          r_credits <= FULL;
          r_state   <= ACTIVE;
        end
        ACTIVE: begin
          r_linkEnq <= w_fire;
          r_credits <= w_nextCredits;
          if (bus.CLR) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          r_credits <= w_nextCredits;
          if (w_nextCredits == FULL) begin
            r_state   <= ACTIVE;
            r_clrDone <= 1'b1;
          end
        end
        default: begin
          r_state <= INIT;
        end
      endcase
    end
  end

`ifdef TOKEN_CREDIT_TX_CHECK_EN
  logic r_err;
  logic w_overflow;
  logic w_initRet;

  assign w_overflow = (r_state != INIT) && bus.CRD_RET && !w_fire && w_atMax;
  assign w_initRet  = (r_state == INIT) && bus.CRD_RET;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_err <= 1'b0;
    end else if (w_overflow || w_initRet) begin
      r_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (!RST && w_overflow) begin
      $display("token_credit_tx: credit overflow (%m)");
    end
    if (!RST && w_initRet) begin
      $display("token_credit_tx: return during init (%m)");
    end
  end
`endif

  assign bus.ERR = r_err;
`else
  assign bus.ERR = 1'b0;
`endif

`ifndef SYNTHESIS
  creditsBounded: assert property (@(posedge CLK) disable iff (RST)
    r_credits <= FULL);
  doneMeansHome: assert property (@(posedge CLK) disable iff (RST)
    r_clrDone |-> (r_credits == FULL));
`endif

  assign bus.RDY        = w_rdy;
  assign bus.LINK_ENQ   = r_linkEnq;
  assign bus.CLR_DONE   = r_clrDone;
  assign bus.CREDIT_CNT = r_credits;

endmodule
